// File: rtl/pipeline_hazard_ctrl.sv
// Control-path sequencer for a 5-stage MIPS pipeline: carries decoded control through
// ID/EX, EX/MEM and MEM/WB and resolves freezes, taken branches, load-use stalls and jumps.
module pipeline_hazard_ctrl #(
   parameter int AW     = 5,
   parameter bit FWD_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [9:0]    id_ctrl,
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   input  logic [AW-1:0] id_rd,
   input  logic          ex_branch_taken,
   input  logic          dmem_ready,
   output logic          pc_write,
   output logic          ifid_write,
   output logic          ifid_flush,
   output logic [1:0]    pc_src,
   output logic [4:0]    ex_ctrl,
   output logic [AW-1:0] ex_rs,
   output logic [AW-1:0] ex_rt,
   output logic [1:0]    mem_ctrl,
   output logic [1:0]    wb_ctrl,
   output logic [AW-1:0] wb_dst,
   output logic [1:0]    forward_a,
   output logic [1:0]    forward_b
);

   localparam int C_REGDST   = 9;
   localparam int C_ALUSRC   = 8;
   localparam int C_MEMTOREG = 7;
   localparam int C_REGWRITE = 6;
   localparam int C_MEMREAD  = 5;
   localparam int C_MEMWRITE = 4;
   localparam int C_BRANCH   = 3;
   localparam int C_JUMP     = 2;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] FWD_NONE  = 2'b00;
   localparam logic [1:0] FWD_WB    = 2'b01;
   localparam logic [1:0] FWD_MEM   = 2'b10;

   typedef struct packed {
      logic          vld;
      logic          regdst;
      logic          alusrc;
      logic          memtoreg;
      logic          regwrite;
      logic          memread;
      logic          memwrite;
      logic          branch;
      logic [1:0]    aluop;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] dst;
   } ex_t;

   typedef struct packed {
      logic          vld;
      logic          memtoreg;
      logic          regwrite;
      logic          memread;
      logic          memwrite;
      logic [AW-1:0] dst;
   } mem_t;

   typedef struct packed {
      logic          vld;
      logic          memtoreg;
      logic          regwrite;
      logic [AW-1:0] dst;
   } wb_t;

   typedef enum logic [2:0] {
      ACT_NORMAL,
      ACT_JUMP,
      ACT_STALL,
      ACT_BRANCH,
      ACT_FREEZE,
      ACT_RESET
   } act_t;

   ex_t  ex_p0;
   mem_t mem_p1;
   wb_t  wb_p2;

   ex_t  id_word;
   logic id_uses_rt;
   logic freeze;
   logic load_use;
   logic raw_stall;
   logic stall;
   act_t act;

   // A nonzero destination that matches a source the ID instruction actually reads.
   function automatic logic dst_hit(input logic [AW-1:0] dst,
                                    input logic [AW-1:0] rs,
                                    input logic [AW-1:0] rt,
                                    input logic          use_rt);
      return (dst != '0) && ((dst == rs) || (use_rt && (dst == rt)));
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                          input mem_t          m,
                                          input wb_t           w);
      logic [1:0] sel;
      sel = FWD_NONE;
      if (m.vld && m.regwrite && (m.dst != '0) && (m.dst == src))
         sel = FWD_MEM;
      else if (w.vld && w.regwrite && (w.dst != '0) && (w.dst == src))
         sel = FWD_WB;
      return sel;
   endfunction

   function automatic mem_t ex_to_mem(input ex_t e);
      mem_t m;
      m.vld      = e.vld;
      m.memtoreg = e.memtoreg;
      m.regwrite = e.regwrite;
      m.memread  = e.memread;
      m.memwrite = e.memwrite;
      m.dst      = e.dst;
      return m;
   endfunction

   function automatic wb_t mem_to_wb(input mem_t m);
      wb_t w;
      w.vld      = m.vld;
      w.memtoreg = m.memtoreg;
      w.regwrite = m.regwrite;
      w.dst      = m.dst;
      return w;
   endfunction

   // ID stage: decode the control word into the EX-bound record
   always_comb begin
      id_word          = '0;
      id_word.vld      = 1'b1;
      id_word.regdst   = id_ctrl[C_REGDST];
      id_word.alusrc   = id_ctrl[C_ALUSRC];
      id_word.memtoreg = id_ctrl[C_MEMTOREG];
      id_word.regwrite = id_ctrl[C_REGWRITE];
      id_word.memread  = id_ctrl[C_MEMREAD];
      id_word.memwrite = id_ctrl[C_MEMWRITE];
      // Jump is resolved in ID, so a stray Branch bit must not re-trigger in EX.
      id_word.branch   = id_ctrl[C_BRANCH] & ~id_ctrl[C_JUMP];
      id_word.aluop    = id_ctrl[1:0];
      id_word.rs       = id_rs;
      id_word.rt       = id_rt;
      if (id_ctrl[C_REGWRITE])
         id_word.dst = id_ctrl[C_REGDST] ? id_rd : id_rt;
      id_uses_rt = ~id_ctrl[C_ALUSRC] | id_ctrl[C_MEMWRITE];
   end

   always_comb begin
      freeze    = mem_p1.vld & (mem_p1.memread | mem_p1.memwrite) & ~dmem_ready;
      load_use  = ex_p0.vld & ex_p0.memread & dst_hit(ex_p0.dst, id_rs, id_rt, id_uses_rt);
      raw_stall = 1'b0;
      // Without forwarding every in-flight producer ahead of WB blocks its consumer.
      if (!FWD_EN)
         raw_stall = dst_hit(ex_p0.dst, id_rs, id_rt, id_uses_rt) |
                     dst_hit(mem_p1.dst, id_rs, id_rt, id_uses_rt);
      stall = load_use | raw_stall;
   end

   always_comb begin
      act = ACT_NORMAL;
      if (rst)
         act = ACT_RESET;
      else if (freeze)
         act = ACT_FREEZE;
      else if (ex_branch_taken)
         act = ACT_BRANCH;
      else if (stall)
         act = ACT_STALL;
      else if (id_ctrl[C_JUMP])
         act = ACT_JUMP;
   end

   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      pc_src     = PC_SEQ;
      case (act)
         ACT_RESET: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
         end
         ACT_FREEZE: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
         end
         ACT_BRANCH: begin
            pc_src     = PC_BRANCH;
            ifid_flush = 1'b1;
         end
         ACT_STALL: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
         end
         ACT_JUMP: begin
            pc_src     = PC_JUMP;
            ifid_flush = 1'b1;
         end
         default: ;
      endcase
   end

   // ID/EX, EX/MEM, MEM/WB control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_p0  <= '0;
         mem_p1 <= '0;
         wb_p2  <= '0;
      end else begin
         case (act)
            // EX and MEM hold; WB empties so the held instruction cannot write twice.
            ACT_FREEZE: wb_p2 <= '0;
            ACT_BRANCH, ACT_STALL: begin
               ex_p0  <= '0;
               mem_p1 <= ex_to_mem(ex_p0);
               wb_p2  <= mem_to_wb(mem_p1);
            end
            default: begin
               ex_p0  <= id_word;
               mem_p1 <= ex_to_mem(ex_p0);
               wb_p2  <= mem_to_wb(mem_p1);
            end
         endcase
      end
   end

   // EX forwarding selects from registered downstream state
   generate
      if (FWD_EN) begin : g_fwd
         assign forward_a = fwd_sel(ex_p0.rs, mem_p1, wb_p2);
         assign forward_b = fwd_sel(ex_p0.rt, mem_p1, wb_p2);
      end else begin : g_nofwd
         assign forward_a = FWD_NONE;
         assign forward_b = FWD_NONE;
      end
   endgenerate

   assign ex_ctrl  = {ex_p0.regdst, ex_p0.alusrc, ex_p0.branch, ex_p0.aluop};
   assign ex_rs    = ex_p0.rs;
   assign ex_rt    = ex_p0.rt;
   assign mem_ctrl = {mem_p1.memread, mem_p1.memwrite};
   assign wb_ctrl  = {wb_p2.memtoreg, wb_p2.regwrite};
   assign wb_dst   = wb_p2.dst;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (forwarding on/off) checked every cycle
// against an instruction-level pipeline model, plus hand-computed literal checkpoints.
module tb_pipeline_hazard_ctrl;

   localparam logic [9:0] NOP = 10'b0000000000;
   localparam logic [9:0] ADD = 10'b1001000010;
   localparam logic [9:0] LW  = 10'b0111100000;
   localparam logic [9:0] SW  = 10'b0100010000;
   localparam logic [9:0] BEQ = 10'b0000001001;
   localparam logic [9:0] JMP = 10'b0000001100;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] id_ctrl;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       bt, rdy;

   logic       pw1, iw1, fl1, pw0, iw0, fl0;
   logic [1:0] ps1, mc1, wc1, fa1, fb1, ps0, mc0, wc0, fa0, fb0;
   logic [4:0] exc1, ers1, ert1, wd1, exc0, ers0, ert0, wd0;

   int tests = 0;
   int fails = 0;
   bit live  = 1'b0;

   typedef struct packed {
      logic [9:0] c;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dst;
   } slot_t;

   slot_t m [2][3];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.AW(5), .FWD_EN(1'b1)) u1 (
      .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_branch_taken(bt), .dmem_ready(rdy), .pc_write(pw1), .ifid_write(iw1),
      .ifid_flush(fl1), .pc_src(ps1), .ex_ctrl(exc1), .ex_rs(ers1), .ex_rt(ert1),
      .mem_ctrl(mc1), .wb_ctrl(wc1), .wb_dst(wd1), .forward_a(fa1), .forward_b(fb1));

   pipeline_hazard_ctrl #(.AW(5), .FWD_EN(1'b0)) u0 (
      .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_branch_taken(bt), .dmem_ready(rdy), .pc_write(pw0), .ifid_write(iw0),
      .ifid_flush(fl0), .pc_src(ps0), .ex_ctrl(exc0), .ex_rs(ers0), .ex_rt(ert0),
      .mem_ctrl(mc0), .wb_ctrl(wc0), .wb_dst(wd0), .forward_a(fa0), .forward_b(fb0));

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit hz(input logic [4:0] d, input logic [9:0] c,
                             input logic [4:0] rs, input logic [4:0] rt);
      bit urt;
      urt = !c[8] || c[4];
      return (d != 0) && ((d == rs) || (urt && (d == rt)));
   endfunction

   function automatic logic [1:0] fsel(input logic [4:0] src, input slot_t me, input slot_t wb);
      if (me.c[6] && me.dst != 0 && me.dst == src) return 2'b10;
      if (wb.c[6] && wb.dst != 0 && wb.dst == src) return 2'b01;
      return 2'b00;
   endfunction

   // Model: mode 0 reset, 1 freeze, 2 branch, 3 stall, 4 jump, 5 normal
   task automatic model_step(input int k, input logic pw, input logic iw, input logic fl,
                             input logic [1:0] ps, input logic [4:0] exc,
                             input logic [4:0] ers, input logic [4:0] ert,
                             input logic [1:0] mc, input logic [1:0] wc,
                             input logic [4:0] wd, input logic [1:0] fa, input logic [1:0] fb);
      slot_t ex, me, wb, nw;
      int    mode;
      bit    fwd, blocked;
      string t;
      ex  = m[k][0];
      me  = m[k][1];
      wb  = m[k][2];
      fwd = (k == 1);
      t   = $sformatf("u%0d", k);
      nw.c = id_ctrl;
      if (id_ctrl[2]) nw.c[3] = 1'b0;
      nw.rs  = id_rs;
      nw.rt  = id_rt;
      nw.dst = id_ctrl[6] ? (id_ctrl[9] ? id_rd : id_rt) : 5'd0;
      blocked = (ex.c[5] && hz(ex.dst, id_ctrl, id_rs, id_rt)) ||
                (!fwd && (hz(ex.dst, id_ctrl, id_rs, id_rt) || hz(me.dst, id_ctrl, id_rs, id_rt)));
      if (rst) mode = 0;
      else if ((me.c[5] || me.c[4]) && !rdy) mode = 1;
      else if (bt) mode = 2;
      else if (blocked) mode = 3;
      else if (id_ctrl[2]) mode = 4;
      else mode = 5;
      chk({t, ".pc_write"},   10'(pw), 10'((mode == 0 || mode == 1 || mode == 3) ? 1'b0 : 1'b1));
      chk({t, ".ifid_write"}, 10'(iw), 10'((mode == 0 || mode == 1 || mode == 3) ? 1'b0 : 1'b1));
      chk({t, ".ifid_flush"}, 10'(fl), 10'((mode == 0 || mode == 2 || mode == 4) ? 1'b1 : 1'b0));
      chk({t, ".pc_src"},     10'(ps), 10'((mode == 2) ? 2'b01 : (mode == 4) ? 2'b10 : 2'b00));
      if (live) begin
         chk({t, ".ex_ctrl"},   10'(exc), 10'({ex.c[9], ex.c[8], ex.c[3], ex.c[1:0]}));
         chk({t, ".ex_rs"},     10'(ers), 10'(ex.rs));
         chk({t, ".ex_rt"},     10'(ert), 10'(ex.rt));
         chk({t, ".mem_ctrl"},  10'(mc),  10'({me.c[5], me.c[4]}));
         chk({t, ".wb_ctrl"},   10'(wc),  10'({wb.c[7], wb.c[6]}));
         chk({t, ".wb_dst"},    10'(wd),  10'(wb.dst));
         chk({t, ".forward_a"}, 10'(fa),  10'(fwd ? fsel(ex.rs, me, wb) : 2'b00));
         chk({t, ".forward_b"}, 10'(fb),  10'(fwd ? fsel(ex.rt, me, wb) : 2'b00));
      end
      case (mode)
         0: begin m[k][0] = '0; m[k][1] = '0; m[k][2] = '0; end
         1: m[k][2] = '0;
         2, 3: begin m[k][2] = me; m[k][1] = ex; m[k][0] = '0; end
         default: begin m[k][2] = me; m[k][1] = ex; m[k][0] = nw; end
      endcase
   endtask

   task automatic drive(input logic r, input logic [9:0] c, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic b, input logic ready);
      rst = r; id_ctrl = c; id_rs = s; id_rt = t; id_rd = d; bt = b; rdy = ready;
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      model_step(1, pw1, iw1, fl1, ps1, exc1, ers1, ert1, mc1, wc1, wd1, fa1, fb1);
      model_step(0, pw0, iw0, fl0, ps0, exc0, ers0, ert0, mc0, wc0, wd0, fa0, fb0);
      if (rst) live = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, NOP, 0, 0, 0, 0, 1);
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; id_ctrl = NOP; id_rs = 0; id_rt = 0; id_rd = 0; bt = 1'b0; rdy = 1'b1;
      @(posedge clk);
      #1;
      // reset
      drive(1, NOP, 0, 0, 0, 0, 1);
      chk("rst.pc_write", 10'(pw1), 10'd0);
      chk("rst.ifid_write", 10'(iw1), 10'd0);
      chk("rst.ifid_flush", 10'(fl1), 10'd1);
      chk("rst.pc_src", 10'(ps1), 10'd0);
      tick();
      drive(1, NOP, 0, 0, 0, 0, 1);
      tick();
      // load-use: lw $2,0($1); add $3,$2,$4
      drive(0, LW, 1, 2, 0, 0, 1);
      chk("first.pc_write", 10'(pw1), 10'd1);
      tick();
      drive(0, ADD, 2, 4, 3, 0, 1);
      chk("lu.pc_write", 10'(pw1), 10'd0);
      chk("lu.ifid_write", 10'(iw1), 10'd0);
      tick();
      drive(0, ADD, 2, 4, 3, 0, 1);
      chk("lu.ex_bubble", 10'(exc1), 10'd0);
      chk("lu.resume", 10'(pw1), 10'd1);
      tick();
      drive(0, NOP, 0, 0, 0, 0, 1);
      chk("lu.forward_a", 10'(fa1), 10'b01);
      chk("lu.forward_b", 10'(fb1), 10'b00);
      tick();
      // back-to-back ALU: add $2,$1,$1; sub $5,$2,$2
      drive(0, ADD, 1, 1, 2, 0, 1);
      tick();
      drive(0, ADD, 2, 2, 5, 0, 1);
      chk("alu.no_stall", 10'(pw1), 10'd1);
      tick();
      drive(0, NOP, 0, 0, 0, 0, 1);
      chk("alu.forward_a", 10'(fa1), 10'b10);
      chk("alu.forward_b", 10'(fb1), 10'b10);
      tick();
      // destination $0 is never forwarded
      drive(0, ADD, 1, 1, 0, 0, 1);
      tick();
      drive(0, ADD, 0, 0, 6, 0, 1);
      tick();
      drive(0, NOP, 0, 0, 0, 0, 1);
      chk("zero.forward_a", 10'(fa1), 10'b00);
      chk("zero.forward_b", 10'(fb1), 10'b00);
      tick();
      // taken branch
      drive(0, BEQ, 1, 2, 0, 0, 1);
      tick();
      drive(0, ADD, 1, 1, 7, 1, 1);
      chk("br.pc_src", 10'(ps1), 10'b01);
      chk("br.ifid_flush", 10'(fl1), 10'd1);
      chk("br.ex_ctrl", 10'(exc1), 10'b00101);
      tick();
      drive(0, NOP, 0, 0, 0, 0, 1);
      chk("br.ex_bubble", 10'(exc1), 10'd0);
      tick();
      // jump with a stray Branch bit
      drive(0, JMP, 0, 0, 0, 0, 1);
      chk("j.pc_src", 10'(ps1), 10'b10);
      chk("j.ifid_flush", 10'(fl1), 10'd1);
      tick();
      drive(0, NOP, 0, 0, 0, 0, 1);
      chk("j.ex_ctrl", 10'(exc1), 10'd0);
      chk("j.pc_src_after", 10'(ps1), 10'b00);
      chk("j.flush_once", 10'(fl1), 10'd0);
      tick();
      // sw in MEM with dmem_ready low for 3 cycles
      drive(0, SW, 1, 2, 0, 0, 1);
      tick();
      nops(1);
      drive(0, ADD, 1, 1, 7, 0, 0);
      chk("frz.pc_write1", 10'(pw1), 10'd0);
      chk("frz.ifid_flush", 10'(fl1), 10'd0);
      tick();
      drive(0, ADD, 1, 1, 7, 0, 0);
      chk("frz.pc_write2", 10'(pw1), 10'd0);
      chk("frz.wb_ctrl", 10'(wc1), 10'd0);
      chk("frz.mem_hold", 10'(mc1), 10'b01);
      tick();
      drive(0, ADD, 1, 1, 7, 0, 0);
      chk("frz.pc_write3", 10'(pw1), 10'd0);
      tick();
      drive(0, ADD, 1, 1, 7, 0, 1);
      chk("frz.resume", 10'(pw1), 10'd1);
      tick();
      nops(2);
      // freeze overlapping a taken branch
      drive(0, SW, 1, 2, 0, 0, 1);
      tick();
      drive(0, BEQ, 1, 2, 0, 0, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, ADD, 1, 1, 7, 1, 0);
         chk("fbr.deferred", 10'(ps1), 10'b00);
         chk("fbr.pc_write", 10'(pw1), 10'd0);
         tick();
      end
      drive(0, ADD, 1, 1, 7, 1, 1);
      chk("fbr.pc_src", 10'(ps1), 10'b01);
      chk("fbr.ifid_flush", 10'(fl1), 10'd1);
      tick();
      nops(3);
      // no forwarding: add $2,$1,$1; add $3,$2,$2
      drive(0, ADD, 1, 1, 2, 0, 1);
      tick();
      drive(0, ADD, 2, 2, 3, 0, 1);
      chk("nf.stall1", 10'(pw0), 10'd0);
      chk("nf.fwd_instance_runs", 10'(pw1), 10'd1);
      tick();
      drive(0, ADD, 2, 2, 3, 0, 1);
      chk("nf.stall2", 10'(pw0), 10'd0);
      chk("h.forward_a_mem", 10'(fa1), 10'b10);
      tick();
      drive(0, ADD, 2, 2, 3, 0, 1);
      chk("nf.resume", 10'(pw0), 10'd1);
      chk("h.forward_a_wb", 10'(fa1), 10'b01);
      tick();
      drive(0, NOP, 0, 0, 0, 0, 1);
      chk("nf.forward_a", 10'(fa0), 10'b00);
      tick();
      nops(3);
      // EX/MEM wins over MEM/WB
      drive(0, ADD, 1, 1, 2, 0, 1);
      tick();
      drive(0, ADD, 4, 4, 2, 0, 1);
      tick();
      drive(0, ADD, 2, 2, 8, 0, 1);
      tick();
      drive(0, NOP, 0, 0, 0, 0, 1);
      chk("prio.forward_a", 10'(fa1), 10'b10);
      chk("prio.forward_b", 10'(fb1), 10'b10);
      tick();
      nops(3);
      // reset in the middle of a freeze
      drive(0, SW, 1, 2, 0, 0, 1);
      tick();
      nops(1);
      drive(0, NOP, 0, 0, 0, 0, 0);
      chk("rf.frozen", 10'(pw1), 10'd0);
      tick();
      drive(1, NOP, 0, 0, 0, 0, 0);
      chk("rf.rst_flush", 10'(fl1), 10'd1);
      tick();
      drive(0, NOP, 0, 0, 0, 0, 0);
      chk("rf.pc_write", 10'(pw1), 10'd1);
      chk("rf.mem_ctrl", 10'(mc1), 10'd0);
      tick();
      nops(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
